i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 141 ++++++++++++++
 tb/tb_i2s_rx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes bclk/adclrck/adcdat into clk_50, captures MSB-first channel words
// after the one-bit I2S delay slot, and presents left/right pairs on a valid/ready output.
module i2s_rx #(
   parameter int unsigned DATA_W = 24
) (
   input  logic              clk_50,
   input  logic              reset,
   input  logic              configured,
   input  logic              bclk,
   input  logic              adclrck,
   input  logic              adcdat,
   output logic [DATA_W-1:0] left_data,
   output logic [DATA_W-1:0] right_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun,
   output logic              frame_err
);

   localparam int unsigned CntW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      StIdle,
      StSkip,
      StShift,
      StHold
   } state_t;

   state_t            state;
   logic              bclk_meta, bclk_sync, bclk_prev;
   logic              lr_meta, lr_sync, lr_last;
   logic              dat_meta, dat_sync;
   logic              channel;
   logic              left_ok;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] left_hold;
   logic [CntW-1:0]   bit_cnt;

   logic              brise;
   logic              lr_edge;
   logic              capturing;
   logic [DATA_W-1:0] shift_word;
   logic [CntW-1:0]   shift_cnt;
   logic              word_done;
   logic              frame_load;

   assign brise   = bclk_sync & ~bclk_prev;
   assign lr_edge = brise & (lr_sync != lr_last);

   // The first captured bit (in SKIP) starts a fresh word; later bits shift into the LSB end.
   always_comb begin
      capturing  = (state == StSkip) || (state == StShift);
      shift_word = (state == StSkip) ? DATA_W'(dat_sync) : ((shreg << 1) | DATA_W'(dat_sync));
      shift_cnt  = (state == StSkip) ? CntW'(1) : (bit_cnt + CntW'(1));
      word_done  = configured && brise && !lr_edge && capturing &&
                   (shift_cnt == CntW'(DATA_W));
      frame_load = word_done && channel && left_ok;
   end

   always_ff @(posedge clk_50) begin
      if (reset) begin
         bclk_meta  <= 1'b0;
         bclk_sync  <= 1'b0;
         bclk_prev  <= 1'b0;
         lr_meta    <= 1'b0;
         lr_sync    <= 1'b0;
         lr_last    <= 1'b0;
         dat_meta   <= 1'b0;
         dat_sync   <= 1'b0;
         state      <= StIdle;
         channel    <= 1'b0;
         left_ok    <= 1'b0;
         shreg      <= '0;
         left_hold  <= '0;
         bit_cnt    <= '0;
         left_data  <= '0;
         right_data <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         bclk_meta <= bclk;
         bclk_sync <= bclk_meta;
         bclk_prev <= bclk_sync;
         lr_meta   <= adclrck;
         lr_sync   <= lr_meta;
         dat_meta  <= adcdat;
         dat_sync  <= dat_meta;

         // Word-clock history advances on every bit event, even while unconfigured.
         if (brise) begin
            lr_last <= lr_sync;
         end

         if (!configured) begin
            state   <= StIdle;
            left_ok <= 1'b0;
         end else if (brise) begin
            if (lr_edge) begin
               if (state == StShift) begin
                  frame_err <= 1'b1;
               end
               state   <= StSkip;
               channel <= lr_sync;
            end else begin
               case (state)
                  StSkip, StShift: begin
                     shreg   <= shift_word;
                     bit_cnt <= shift_cnt;
                     if (shift_cnt == CntW'(DATA_W)) begin
                        state <= StHold;
                        if (!channel) begin
                           left_hold <= shift_word;
                           left_ok   <= 1'b1;
                        end else begin
                           left_ok <= 1'b0;
                        end
                     end else begin
                        state <= StShift;
                     end
                  end
                  default: begin
                  end
               endcase
            end
         end

         if (frame_load) begin
            left_data  <= left_hold;
            right_data <= shift_word;
            out_valid  <= 1'b1;
            if (out_valid && !out_ready) begin
               overrun <= 1'b1;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: slot-level codec driver with a word/frame reference model feeding a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_i2s_rx;

   localparam int DW = 24;

   logic          clk_50 = 1'b0;
   logic          reset = 1'b1;
   logic          configured = 1'b1;
   logic          bclk = 1'b0;
   logic          adclrck = 1'b0;
   logic          adcdat = 1'b0;
   logic [DW-1:0] left_data, right_data;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          overrun, frame_err;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [2*DW-1:0] exp_q[$];
   logic            m_prev_lr = 1'b0;
   logic            m_left_ok = 1'b0;
   logic            m_partial = 1'b0;
   logic            m_err = 1'b0;
   logic            m_ovr = 1'b0;
   logic [DW-1:0]   m_left = '0;

   int   rdy_mode = 1;  // 0 = never ready, 1 = always ready, 2 = random
   logic allow_ovw = 1'b0;

   i2s_rx #(.DATA_W(DW)) dut (
      .clk_50     (clk_50),
      .reset      (reset),
      .configured (configured),
      .bclk       (bclk),
      .adclrck    (adclrck),
      .adcdat     (adcdat),
      .left_data  (left_data),
      .right_data (right_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .overrun    (overrun),
      .frame_err  (frame_err)
   );

   always #10 clk_50 = ~clk_50;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic lr, input logic d);
      adclrck = lr;
      adcdat  = d;
      #80 bclk = 1'b1;
      #80 bclk = 1'b0;
   endtask

   task automatic push_frame(input logic [2*DW-1:0] f);
      if (rdy_mode == 0 && exp_q.size() > 0) begin
         exp_q[exp_q.size()-1] = f;
         m_ovr = 1'b1;
      end else begin
         exp_q.push_back(f);
      end
   endtask

   // One word-clock slot of nbits bit clocks: delay bit, word MSB first, random padding.
   task automatic do_slot(input logic lr, input logic [DW-1:0] w, input int nbits);
      logic edge_m;
      edge_m    = (lr != m_prev_lr);
      m_prev_lr = lr;
      if (edge_m && configured) begin
         if (m_partial) m_err = 1'b1;
         m_partial = 1'b0;
         if (nbits - 1 >= DW) begin
            if (!lr) begin
               m_left    = w;
               m_left_ok = 1'b1;
            end else if (m_left_ok) begin
               push_frame({m_left, w});
               m_left_ok = 1'b0;
            end
         end else if (nbits >= 2) begin
            m_partial = 1'b1;
         end
      end
      for (int i = 0; i < nbits; i++) begin
         if (i >= 1 && i <= DW) send_bit(lr, w[DW-i]);
         else send_bit(lr, ($urandom & 1) != 0);
      end
   endtask

   task automatic do_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
      do_slot(1'b0, l, 32);
      do_slot(1'b1, r, 32);
   endtask

   task automatic set_cfg(input logic c);
      configured = c;
      if (!c) begin
         m_left_ok = 1'b0;
         m_partial = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_prev_lr = 1'b0;
      m_left_ok = 1'b0;
      m_partial = 1'b0;
      m_err     = 1'b0;
      m_ovr     = 1'b0;
      exp_q.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_50);
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_flags(input string name);
      chk({name, "_frame_err"}, 64'(frame_err), 64'(m_err));
      chk({name, "_overrun"}, 64'(overrun), 64'(m_ovr));
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_left"}, 64'(left_data), 64'd0);
      chk({name, "_right"}, 64'(right_data), 64'd0);
      chk({name, "_valid"}, 64'(out_valid), 64'd0);
      chk({name, "_overrun"}, 64'(overrun), 64'd0);
      chk({name, "_frame_err"}, 64'(frame_err), 64'd0);
   endtask

   initial begin : ready_drv
      forever begin
         @(posedge clk_50);
         #2;
         if (rdy_mode == 2) out_ready = ($urandom & 1) != 0;
         else out_ready = (rdy_mode == 1);
      end
   end

   initial begin : monitor
      logic            hold_prev;
      logic [DW-1:0]   hl, hr;
      logic [2*DW-1:0] f;
      hold_prev = 1'b0;
      hl = '0;
      hr = '0;
      forever begin
         @(negedge clk_50);
         if (reset) begin
            hold_prev = 1'b0;
         end else begin
            if (hold_prev) begin
               checks++;
               if (!out_valid || (!allow_ovw && (left_data != hl || right_data != hr))) begin
                  errors++;
                  $display("FAIL hold: valid=%0b data=%h/%h expected valid=1 data=%h/%h",
                           out_valid, left_data, right_data, hl, hr);
               end
            end
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL frame: got unexpected %h/%h expected no frame",
                           left_data, right_data);
               end else begin
                  f = exp_q.pop_front();
                  if ({left_data, right_data} != f) begin
                     errors++;
                     $display("FAIL frame: got %h/%h expected %h/%h",
                              left_data, right_data, f[2*DW-1:DW], f[DW-1:0]);
                  end
               end
            end
            hold_prev = out_valid && !out_ready;
            hl = left_data;
            hr = right_data;
         end
      end
   end

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [DW-1:0] l, r;
      repeat (4) @(negedge clk_50);
      reset = 1'b0;
      chk_zero("reset");

      // Stream joins mid right slot: that word has no left partner and is dropped.
      do_slot(1'b1, DW'($urandom), 28);
      do_frame(24'h800001, 24'h7FFFFE);
      do_frame(24'h800001, 24'h7FFFFE);
      drain("basic_drain");
      chk_flags("basic");

      // Randomized slot lengths, data and consumer back-pressure.
      rdy_mode = 2;
      for (int i = 0; i < 20; i++) begin
         do_slot(1'b0, DW'($urandom), $urandom_range(DW + 1, 40));
         do_slot(1'b1, DW'($urandom), $urandom_range(DW + 1, 40));
      end
      drain("random_drain");
      rdy_mode = 1;
      chk_flags("random");

      // Left word cut short after 10 data bits.
      do_slot(1'b0, DW'($urandom), 11);
      do_slot(1'b1, DW'($urandom), 32);
      l = DW'($urandom);
      r = DW'($urandom);
      do_frame(l, r);
      drain("short_drain");
      chk_flags("short");

      // Unconfigured for one left slot.
      set_cfg(1'b0);
      do_slot(1'b0, DW'($urandom), 32);
      set_cfg(1'b1);
      do_slot(1'b1, DW'($urandom), 32);
      do_frame(DW'($urandom), DW'($urandom));
      drain("cfg_drain");
      chk_flags("cfg");

      // Two frames with no consumer: second overwrites first.
      rdy_mode  = 0;
      allow_ovw = 1'b1;
      repeat (4) @(negedge clk_50);
      do_frame(24'h111111, 24'h222222);
      do_frame(24'h333333, 24'h444444);
      chk("ovr_valid", 64'(out_valid), 64'd1);
      chk("ovr_left", 64'(left_data), 64'h333333);
      chk("ovr_right", 64'(right_data), 64'h444444);
      chk_flags("ovr");
      rdy_mode = 1;
      drain("ovr_drain");
      allow_ovw = 1'b0;

      // Reset mid left word.
      do_slot(1'b0, DW'($urandom), 12);
      @(negedge clk_50);
      reset = 1'b1;
      @(negedge clk_50);
      chk_zero("midreset");
      reset = 1'b0;
      model_reset();
      do_slot(1'b0, DW'($urandom), 20);
      do_slot(1'b1, DW'($urandom), 32);
      do_frame(DW'($urandom), DW'($urandom));
      drain("final_drain");
      chk_flags("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
